// File: rtl/ahb_burst_arbiter.sv
// Two-master burst arbiter that shares one AHB-Lite port between the I-cache (F) and D-cache (M).
// M wins ties; after MAX_CONSEC back-to-back M wins while F waits, F is forced through.
module ahb_burst_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int MAX_CONSEC  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           HRequestF,
  input  logic [31:0]                    HAddrF,
  input  logic                           HRequestM,
  input  logic                           HWriteM,
  input  logic [31:0]                    HAddrM,
  input  logic                           HReady,
  output logic [31:0]                    HAddr,
  output logic                           HWrite,
  output logic                           HRequest,
  output logic                           HReadyF,
  output logic                           HReadyM,
  output logic                           GrantF,
  output logic                           GrantM,
  output logic [$clog2(BLOCK_WORDS)-1:0] Beat
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int CONS_W = $clog2(MAX_CONSEC) + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(MAX_CONSEC);
  localparam logic [31:0]       LINE_MASK = ~32'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_M = 2'b10
  } state_t;

  state_t            r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [CONS_W-1:0] r_consec;

  logic              w_busy_f;
  logic              w_busy_m;
  logic              w_busy;
  logic              w_owner_req;
  logic              w_last_beat;
  logic              w_f_forced;
  logic [31:0]       w_line_addr;
  logic [31:0]       w_beat_off;

  assign w_busy_f    = (r_state == BUSY_F);
  assign w_busy_m    = (r_state == BUSY_M);
  assign w_busy      = w_busy_f | w_busy_m;
  assign w_owner_req = w_busy_m ? HRequestM : HRequestF;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_f_forced  = HRequestF & (r_consec == CONS_MAX);

  // Burst FSM: reset wins, an owner dropping its request aborts regardless of HReady,
  // and every burst end returns to IDLE for one turnaround cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_consec <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (HRequestM && !w_f_forced) begin
            r_state <= BUSY_M;
            if (!HRequestF) begin
              r_consec <= '0;
            end else if (r_consec != CONS_MAX) begin
              r_consec <= r_consec + CONS_W'(1);
            end
          end else if (HRequestF) begin
            r_state  <= BUSY_F;
            r_consec <= '0;
          end
        end
        BUSY_F, BUSY_M: begin
          if (!w_owner_req) begin
            r_state <= IDLE;
            r_beat  <= '0;
          end else if (HReady) begin
            if (w_last_beat) begin
              r_state <= IDLE;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  // Bus-side outputs decode straight from state so HReady passes through with no added cycle.
  assign w_line_addr = w_busy_m ? HAddrM : HAddrF;
  assign w_beat_off  = {{(30 - BEAT_W){1'b0}}, r_beat, 2'b00};

  assign HAddr    = w_busy ? ((w_line_addr & LINE_MASK) | w_beat_off) : 32'h0;
  assign HWrite   = w_busy_m & HWriteM;
  assign HRequest = w_busy;
  assign HReadyF  = w_busy_f & HReady;
  assign HReadyM  = w_busy_m & HReady;
  assign GrantF   = w_busy_f;
  assign GrantM   = w_busy_m;
  assign Beat     = r_beat;

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Bench for ahb_burst_arbiter: fixed vector table, directed corner sequences and
// randomized traffic compared against a transaction-level model of the arbiter.
module tb_ahb_burst_arbiter;

  localparam int BW  = 4;
  localparam int MC  = 4;
  localparam int BWB = $clog2(BW);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           HRequestF = 1'b0;
  logic [31:0]    HAddrF = 32'h0;
  logic           HRequestM = 1'b0;
  logic           HWriteM = 1'b0;
  logic [31:0]    HAddrM = 32'h0;
  logic           HReady = 1'b0;
  logic [31:0]    HAddr;
  logic           HWrite;
  logic           HRequest;
  logic           HReadyF;
  logic           HReadyM;
  logic           GrantF;
  logic           GrantM;
  logic [BWB-1:0] Beat;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: who owns the bus (0 none, 1 F, 2 M), beats done, M wins in a row while F waited.
  int m_owner  = 0;
  int m_beat   = 0;
  int m_consec = 0;

  always #5 clk = ~clk;

  ahb_burst_arbiter #(.BLOCK_WORDS(BW), .MAX_CONSEC(MC)) dut (
    .clk(clk), .reset(reset),
    .HRequestF(HRequestF), .HAddrF(HAddrF),
    .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM),
    .HReady(HReady),
    .HAddr(HAddr), .HWrite(HWrite), .HRequest(HRequest),
    .HReadyF(HReadyF), .HReadyM(HReadyM),
    .GrantF(GrantF), .GrantM(GrantM), .Beat(Beat)
  );

  typedef struct {
    logic        rf;
    logic [31:0] af;
    logic        rm;
    logic        wm;
    logic [31:0] am;
    logic        rdy;
    logic        ereq;
    logic        egf;
    logic        egm;
    logic        ehw;
    logic        erf;
    logic        erm;
    logic [31:0] eaddr;
    int          ebeat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rf, input logic [31:0] af, input logic rm, input logic wm,
                              input logic [31:0] am, input logic rdy, input logic ereq,
                              input logic egf, input logic egm, input logic ehw, input logic erf,
                              input logic erm, input logic [31:0] eaddr, input int ebeat);
    vec_t v;
    v.rf = rf; v.af = af; v.rm = rm; v.wm = wm; v.am = am; v.rdy = rdy;
    v.ereq = ereq; v.egf = egf; v.egm = egm; v.ehw = ehw; v.erf = erf; v.erm = erm;
    v.eaddr = eaddr; v.ebeat = ebeat;
    return v;
  endfunction

  function automatic void model_advance();
    bit held;
    if (reset) begin
      m_owner = 0; m_beat = 0; m_consec = 0;
    end else if (m_owner == 0) begin
      if (HRequestF && HRequestM) begin
        if (m_consec == MC) begin
          m_owner = 1; m_consec = 0;
        end else begin
          m_owner = 2; m_consec = m_consec + 1;
        end
      end else if (HRequestM) begin
        m_owner = 2; m_consec = 0;
      end else if (HRequestF) begin
        m_owner = 1; m_consec = 0;
      end
    end else begin
      held = (m_owner == 1) ? HRequestF : HRequestM;
      if (!held) begin
        m_owner = 0; m_beat = 0;
      end else if (HReady) begin
        m_beat = m_beat + 1;
        if (m_beat == BW) begin
          m_owner = 0; m_beat = 0;
        end
      end
    end
  endfunction

  task automatic check_model();
    logic [31:0] line;
    logic [31:0] eaddr;
    line  = (m_owner == 2) ? HAddrM : HAddrF;
    eaddr = (m_owner == 0) ? 32'h0 : ((line & ~32'(BW * 4 - 1)) | 32'(m_beat * 4));
    chk("model.HRequest", 32'(HRequest), 32'(m_owner != 0));
    chk("model.GrantF",   32'(GrantF),   32'(m_owner == 1));
    chk("model.GrantM",   32'(GrantM),   32'(m_owner == 2));
    chk("model.HWrite",   32'(HWrite),   32'((m_owner == 2) && HWriteM));
    chk("model.HReadyF",  32'(HReadyF),  32'((m_owner == 1) && HReady));
    chk("model.HReadyM",  32'(HReadyM),  32'((m_owner == 2) && HReady));
    chk("model.HAddr",    HAddr,         eaddr);
    chk("model.Beat",     32'(Beat),     32'(m_beat));
  endtask

  task automatic step(input bit use_model);
    #2;
    if (use_model) check_model();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    HRequestF = 1'b0; HRequestM = 1'b0; HReady = 1'b0; HWriteM = 1'b0;
    step(0);
    step(0);
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".HRequest"}, 32'(HRequest), 32'h0);
    chk({name, ".Grant"},    32'({GrantF, GrantM}), 32'h0);
    chk({name, ".HReady"},   32'({HReadyF, HReadyM}), 32'h0);
    chk({name, ".HAddr"},    HAddr, 32'h0);
    chk({name, ".HWrite"},   32'(HWrite), 32'h0);
    chk({name, ".Beat"},     32'(Beat), 32'h0);
  endtask

  initial begin
    int owners[$];
    bit prev_busy;

    // F fill, tie won by M (writeback), F burst with wait states, M abort at beat 2.
    vt.push_back(mk(1, 32'h1234, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 32'h1234, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h1230, 0));
    vt.push_back(mk(1, 32'h1234, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h1234, 1));
    vt.push_back(mk(1, 32'h1234, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h1238, 2));
    vt.push_back(mk(1, 32'h1234, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h123C, 3));
    vt.push_back(mk(0, 32'h1234, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 32'h1234, 1, 1, 32'h8000_0040, 1,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 32'h1234, 1, 1, 32'h8000_0040, 1,   1, 0, 1, 1, 0, 1, 32'h8000_0040, 0));
    vt.push_back(mk(1, 32'h1234, 1, 1, 32'h8000_0040, 1,   1, 0, 1, 1, 0, 1, 32'h8000_0044, 1));
    vt.push_back(mk(1, 32'h1234, 1, 1, 32'h8000_0040, 1,   1, 0, 1, 1, 0, 1, 32'h8000_0048, 2));
    vt.push_back(mk(1, 32'h1234, 1, 1, 32'h8000_0040, 1,   1, 0, 1, 1, 0, 1, 32'h8000_004C, 3));
    vt.push_back(mk(0, 32'h1234, 0, 0, 32'h8000_0040, 0,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h2000, 0));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 32'h2004, 1));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 32'h2004, 1));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h2004, 1));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h2008, 2));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 32'h200C, 3));
    vt.push_back(mk(1, 32'h2000, 0, 0, 0, 1,   1, 1, 0, 0, 1, 0, 32'h200C, 3));
    vt.push_back(mk(0, 32'h2000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(0, 0, 1, 0, 32'h4008, 1,   0, 0, 0, 0, 0, 0, 32'h0, 0));
    vt.push_back(mk(0, 0, 1, 0, 32'h4008, 1,   1, 0, 1, 0, 0, 1, 32'h4000, 0));
    vt.push_back(mk(0, 0, 1, 0, 32'h4008, 1,   1, 0, 1, 0, 0, 1, 32'h4004, 1));
    vt.push_back(mk(0, 0, 0, 0, 32'h4008, 1,   1, 0, 1, 0, 0, 1, 32'h4008, 2));
    vt.push_back(mk(0, 0, 0, 0, 32'h4008, 1,   0, 0, 0, 0, 0, 0, 32'h0, 0));

    do_reset();
    chk_idle("reset");

    foreach (vt[i]) begin
      HRequestF = vt[i].rf; HAddrF = vt[i].af;
      HRequestM = vt[i].rm; HWriteM = vt[i].wm; HAddrM = vt[i].am;
      HReady = vt[i].rdy;
      #2;
      chk($sformatf("vec%0d.HRequest", i), 32'(HRequest), 32'(vt[i].ereq));
      chk($sformatf("vec%0d.GrantF", i),   32'(GrantF),   32'(vt[i].egf));
      chk($sformatf("vec%0d.GrantM", i),   32'(GrantM),   32'(vt[i].egm));
      chk($sformatf("vec%0d.HWrite", i),   32'(HWrite),   32'(vt[i].ehw));
      chk($sformatf("vec%0d.HReadyF", i),  32'(HReadyF),  32'(vt[i].erf));
      chk($sformatf("vec%0d.HReadyM", i),  32'(HReadyM),  32'(vt[i].erm));
      chk($sformatf("vec%0d.HAddr", i),    HAddr,         vt[i].eaddr);
      chk($sformatf("vec%0d.Beat", i),     32'(Beat),     32'(vt[i].ebeat));
      @(posedge clk);
      model_advance();
      #1;
    end

    // Starvation: both held with HReady high -> M,M,M,M,F, then M again after the counter clears.
    do_reset();
    HRequestF = 1'b1; HAddrF = 32'h0000_5000;
    HRequestM = 1'b1; HAddrM = 32'h0000_6000; HWriteM = 1'b0;
    HReady = 1'b1;
    prev_busy = 1'b0;
    for (int c = 0; c < 32; c++) begin
      step(1);
      if ((GrantF || GrantM) && !prev_busy) owners.push_back(GrantM ? 2 : 1);
      prev_busy = GrantF || GrantM;
    end
    chk("starve.count", 32'(owners.size() >= 6), 32'h1);
    if (owners.size() >= 6) begin
      chk("starve.b0", 32'(owners[0]), 32'd2);
      chk("starve.b1", 32'(owners[1]), 32'd2);
      chk("starve.b2", 32'(owners[2]), 32'd2);
      chk("starve.b3", 32'(owners[3]), 32'd2);
      chk("starve.b4", 32'(owners[4]), 32'd1);
      chk("starve.b5", 32'(owners[5]), 32'd2);
    end

    // Reset at beat 1 of an F burst, with F still requesting.
    do_reset();
    HRequestF = 1'b1; HAddrF = 32'h0000_7000; HRequestM = 1'b0; HReady = 1'b1;
    step(1);
    step(1);
    chk("rstmid.beat", 32'(Beat), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1;
    chk_idle("rstmid");
    step(1);

    // Non-preemption: M appears at beat 1 of an F burst and waits for IDLE.
    do_reset();
    HRequestF = 1'b1; HAddrF = 32'h0000_3000; HRequestM = 1'b0; HReady = 1'b1;
    HAddrM = 32'h0000_9000; HWriteM = 1'b1;
    step(1);
    step(1);
    HRequestM = 1'b1;
    for (int b = 1; b < BW; b++) begin
      #1;
      chk($sformatf("nopre.beat%0d.GrantF", b), 32'(GrantF), 32'h1);
      chk($sformatf("nopre.beat%0d.GrantM", b), 32'(GrantM), 32'h0);
      step(1);
    end
    HRequestF = 1'b0;
    #1;
    chk_idle("nopre.turn");
    step(1);
    chk("nopre.GrantM", 32'(GrantM), 32'h1);
    chk("nopre.HWrite", 32'(HWrite), 32'h1);
    step(1);

    // Randomized traffic with sticky requests against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 12) HRequestF = ~HRequestF;
      if ($urandom_range(0, 99) < 12) HRequestM = ~HRequestM;
      if (!HRequestF) HAddrF = $urandom;
      if (!HRequestM) begin
        HAddrM = $urandom;
        HWriteM = 1'($urandom_range(0, 1));
      end
      HReady = ($urandom_range(0, 99) < 70);
      step(1);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_burst_arbiter.md
AHB_BURST_ARBITER -- requirements
Module: ahb_burst_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 4, meaning beats per cache-line burst; power of two, 2..16.
REQ-002 Parameter MAX_CONSEC, default 4, meaning consecutive M bursts allowed while F waits before F is forced.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 HRequestF  input  1  instruction-cache burst request; held until burst end.
REQ-006 HAddrF  input  32  instruction-cache line address; stable while HRequestF=1.
REQ-007 HRequestM  input  1  data-cache burst request; held until burst end.
REQ-008 HWriteM  input  1  data-cache burst is a writeback (1) or fill (0); stable while HRequestM=1.
REQ-009 HAddrM  input  32  data-cache line address; stable while HRequestM=1.
REQ-010 HReady  input  1  bus beat-complete strobe from ahb_lite.
REQ-011 HAddr  output  32  beat address to bus.
REQ-012 HWrite  output  1  write enable to bus.
REQ-013 HRequest  output  1  bus request to ahb_lite.
REQ-014 HReadyF  output  1  beat-complete strobe to instruction cache.
REQ-015 HReadyM  output  1  beat-complete strobe to data cache.
REQ-016 GrantF, GrantM  output  1 each  current burst owner.
REQ-017 Beat  output  log2(BLOCK_WORDS)  index of current beat within burst.

Function
REQ-018 States SHALL be IDLE, BUSY_F, BUSY_M; exactly one active.
REQ-019 IDLE: HRequest=0, HWrite=0, HAddr=0, HReadyF=HReadyM=0, GrantF=GrantM=0, Beat=0.
REQ-020 IDLE, only HRequestF=1 -> BUSY_F next edge; only HRequestM=1 -> BUSY_M.
REQ-021 IDLE, both requesting: BUSY_M unless ConsecM==MAX_CONSEC, then BUSY_F.
REQ-022 ConsecM counter (width log2(MAX_CONSEC)+1): +1 on IDLE->BUSY_M with HRequestF=1; cleared on IDLE->BUSY_M with HRequestF=0, on IDLE->BUSY_F, and on reset; saturates at MAX_CONSEC.
REQ-023 BUSY_X: HRequest=1, GrantX=1, HReadyX=HReady, other HReady strobe 0; HWrite=HWriteM in BUSY_M, 0 in BUSY_F.
REQ-024 HAddr in BUSY_X SHALL be {HAddrX[31:log2(BLOCK_WORDS)+2], Beat, 2'b00}; low address bits of HAddrX ignored.
REQ-025 Beat SHALL increment on each cycle with HReady=1 in BUSY state; no change when HReady=0.
REQ-026 Cycle with HReady=1 and Beat==BLOCK_WORDS-1 SHALL end burst: next state IDLE, Beat->0 (one mandatory turnaround cycle; no back-to-back grant).
REQ-027 Owner deasserting its HRequest mid-burst SHALL abort: next state IDLE, Beat->0, irrespective of HReady that cycle; that final HReadyX still passes through combinationally.
REQ-028 Requests from non-owner during a burst SHALL be ignored until IDLE; no preemption.
REQ-029 All outputs SHALL be combinational from state, Beat and inputs; no added latency on HReady pass-through.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, Beat=0, ConsecM=0, including mid-burst; outputs per REQ-019 the following cycle.
REQ-031 reset SHALL take priority over all transitions.

Verification
REQ-032 F-only fill: HRequestF=1, HAddrF=0x0000_1234, HReady high 4 cycles -> HAddr 0x1230,0x1234,0x1238,0x123C, HReadyF pulses 4, then IDLE one cycle.
REQ-033 Simultaneous: HRequestF=HRequestM=1, HWriteM=1, HAddrM=0x8000_0040 -> BUSY_M, HWrite=1, HAddr 0x8000_0040..0x8000_004C; HReadyF stays 0.
REQ-034 Starvation: both held continuously -> 4 M bursts then 1 F burst, ConsecM back to 0.
REQ-035 Wait states: HReady toggling 1,0,0,1,1,0,1 -> Beat advances only on 1s, burst ends after 4th HReady.
REQ-036 Abort/reset: HRequestM dropped at Beat=2 -> IDLE next edge; separately reset at Beat=1 in BUSY_F -> IDLE, all outputs 0.
REQ-037 Non-preemption: M requests at Beat=1 of F burst -> F completes all 4 beats, M granted after IDLE cycle.
